// File: rtl/ps2_pkg.sv
// Shared constants, FSM state encoding and the packed key-event type for the PS/2 scan decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Bytes following E1 in the full pause sequence: 14 77 E1 F0 14 F0 77
  localparam int PS2_PAUSE_TAIL_DEF = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO; a push while full is accepted only if a pop happens in the same cycle.
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_rd_en;
  logic             w_wr_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_rd_en = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);

  // Head is forced to zero when empty so the outputs are clean straight out of reset.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// Set-2 prefix stripper (E0/F0/E1) producing {ext, rel, code} key events into a FWFT FIFO.
// Optional typematic repeat suppression is built when PS2_REPEAT_FILTER_EN is defined.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PAUSE_TAIL = PS2_PAUSE_TAIL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_rel,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ovf,
  input  logic       ovf_clr
);

  localparam int SKW = $clog2(PAUSE_TAIL + 1);

  ps2_state_t r_state;
  ps2_state_t w_state_nxt;
  logic [SKW-1:0] r_skip;
  logic [SKW-1:0] w_skip_nxt;
  ps2_event_t w_cand;
  logic       w_cand_vld;
  logic       w_push;
  logic       w_pop;
  logic       w_drop;
  logic       w_empty;
  logic       w_full;
  ps2_event_t w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_skip  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    w_cand      = '0;
    w_cand_vld  = 1'b0;
    if (rx_err) begin
      w_state_nxt = ST_IDLE;
      w_skip_nxt  = '0;
    end else if (rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == PS2_EXT) begin
            w_state_nxt = ST_EXT;
          end else if (rx_data == PS2_BRK) begin
            w_state_nxt = ST_BRK;
          end else if (rx_data == PS2_PAUSE) begin
            w_state_nxt = ST_PAUSE;
            w_skip_nxt  = SKW'(PAUSE_TAIL);
          end else begin
            w_cand     = '{ext: 1'b0, rel: 1'b0, code: rx_data};
            w_cand_vld = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK) begin
            w_state_nxt = ST_EXT_BRK;
          end else if (rx_data != PS2_EXT) begin
            w_cand      = '{ext: 1'b1, rel: 1'b0, code: rx_data};
            w_cand_vld  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          w_state_nxt = ST_IDLE;
          // A second prefix after F0 is malformed; drop the whole sequence.
          if (rx_data != PS2_BRK && rx_data != PS2_EXT) begin
            w_cand     = '{ext: (r_state == ST_EXT_BRK), rel: 1'b1, code: rx_data};
            w_cand_vld = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (r_skip <= SKW'(1)) begin
            w_cand      = '{ext: 1'b1, rel: 1'b0, code: PS2_PAUSE};
            w_cand_vld  = 1'b1;
            w_skip_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_skip_nxt = r_skip - 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic       r_lm_vld;
  logic       r_lm_ext;
  logic [7:0] r_lm_code;
  logic       w_lm_match;

  assign w_lm_match = r_lm_vld && (r_lm_ext == w_cand.ext) && (r_lm_code == w_cand.code);
  assign w_push     = w_cand_vld && !(!w_cand.rel && w_lm_match);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lm_vld  <= 1'b0;
      r_lm_ext  <= 1'b0;
      r_lm_code <= '0;
    end else if (rx_err) begin
      r_lm_vld <= 1'b0;
    end else if (w_cand_vld) begin
      if (w_cand.rel) begin
        if (w_lm_match) r_lm_vld <= 1'b0;
      end else if (!w_lm_match) begin
        r_lm_vld  <= 1'b1;
        r_lm_ext  <= w_cand.ext;
        r_lm_code <= w_cand.code;
      end
    end
  end
`else
  assign w_push = w_cand_vld;
`endif

  assign w_pop  = ev_ready && !w_empty;
  assign w_drop = w_push && w_full && !w_pop;

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(ps2_event_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_cand),
    .i_pop   (ev_ready),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign ev_valid = !w_empty;
  assign ev_ext   = w_head.ext;
  assign ev_rel   = w_head.rel;
  assign ev_code  = w_head.code;

  // Set has priority over clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf <= 1'b0;
    else if (w_drop)  ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder; expectations adapt to PS2_REPEAT_FILTER_EN.
module tb_ps2_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_rel;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic       ovf;
  logic       ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_scan_decoder #(.FIFO_DEPTH(4), .PAUSE_TAIL(7)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_rel   (ev_rel),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // exp = {ext, rel, code}; also requires ev_valid=1
  task automatic chk_ev(input string tag, input logic [9:0] exp);
    checks++;
    assert ({ev_valid, ev_ext, ev_rel, ev_code} === {1'b1, exp}) else begin
      errors++;
      $error("FAIL %s observed v=%b e=%b r=%b c=%h expected v=1 e=%b r=%b c=%h",
             tag, ev_valid, ev_ext, ev_rel, ev_code, exp[9], exp[8], exp[7:0]);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pop();
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] pseq [8];
    logic [7:0] rseq [6];
    logic       rexp [6];
    logic [9:0] rev  [6];
    pseq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    repeat (2) @(negedge clk);
    chk_ev_reset: begin
      chk_bit("rst_valid", ev_valid, 1'b0);
      chk_bit("rst_ovf", ovf, 1'b0);
      checks++;
      assert ({ev_ext, ev_rel, ev_code} === 10'h000) else begin
        errors++;
        $error("FAIL rst_head observed %h expected 000", {ev_ext, ev_rel, ev_code});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);

    // make / break
    send(8'h1C);
    chk_ev("make_1c", {2'b00, 8'h1C});
    pop();
    chk_bit("empty_after_pop", ev_valid, 1'b0);
    send(8'hF0);
    chk_bit("brk_prefix_only", ev_valid, 1'b0);
    send(8'h1C);
    chk_ev("break_1c", {2'b01, 8'h1C});
    pop();

    // extended make / break
    send(8'hE0);
    chk_bit("ext_prefix_only", ev_valid, 1'b0);
    send(8'h75);
    chk_ev("ext_make_75", {2'b10, 8'h75});
    pop();
    send(8'hE0);
    send(8'hF0);
    chk_bit("ext_brk_prefix_only", ev_valid, 1'b0);
    send(8'h75);
    chk_ev("ext_break_75", {2'b11, 8'h75});
    pop();

    // pause sequence
    for (int i = 0; i < 8; i++) begin
      send(pseq[i]);
      if (i < 7) chk_bit("pause_swallow", ev_valid, 1'b0);
    end
    chk_ev("pause_event", {2'b10, 8'hE1});
    pop();
    chk_bit("pause_single", ev_valid, 1'b0);
    send(8'h1C);
    chk_ev("after_pause_1c", {2'b00, 8'h1C});
    pop();

    // overflow
    for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
    chk_bit("ovf_set", ovf, 1'b1);
    ovf_clr = 1'b1;
    send(8'h15);
    ovf_clr = 1'b0;
    chk_bit("ovf_set_wins", ovf, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk_ev("drain_order", {2'b00, 8'h10 + 8'(i)});
      pop();
    end
    chk_bit("drained_empty", ev_valid, 1'b0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk_bit("ovf_cleared", ovf, 1'b0);

    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
    ev_ready = 1'b1;
    send(8'h24);
    ev_ready = 1'b0;
    chk_bit("push_pop_full_no_ovf", ovf, 1'b0);
    for (int i = 1; i < 5; i++) begin
      chk_ev("push_pop_full_order", {2'b00, 8'h20 + 8'(i)});
      pop();
    end
    chk_bit("push_pop_full_empty", ev_valid, 1'b0);

    // receiver error
    send(8'hF0);
    rx_err = 1'b1;
    @(negedge clk);
    rx_err = 1'b0;
    send(8'h1C);
    chk_ev("err_drops_prefix", {2'b00, 8'h1C});
    pop();
    rx_err = 1'b1;
    send(8'h33);
    rx_err = 1'b0;
    chk_bit("err_discards_byte", ev_valid, 1'b0);

    // typematic repeat
    rseq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
    rev  = '{{2'b00, 8'h1C}, {2'b00, 8'h1C}, {2'b00, 8'h1C}, 10'h000,
             {2'b01, 8'h1C}, {2'b00, 8'h1C}};
`ifdef PS2_REPEAT_FILTER_EN
    rexp = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    rexp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 6; i++) begin
      send(rseq[i]);
      if (rexp[i]) begin
        chk_ev("repeat_event", rev[i]);
        pop();
      end else begin
        chk_bit("repeat_none", ev_valid, 1'b0);
      end
    end

    // reset with entries queued and ovf set
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i));
    pop();
    chk_ev("pre_reset_head", {2'b00, 8'h51});
    chk_bit("pre_reset_ovf", ovf, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_bit("async_rst_valid", ev_valid, 1'b0);
    chk_bit("async_rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_bit("post_rst_empty", ev_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
Name: ps2_scan_decoder

Overview:
- Downstream consumer of the PS/2 keyboard receiver.
- Takes completed scan-code bytes (rx_data plus a one-cycle rx_valid strobe) and strips Set-2 prefixes: E0 (extended), F0 (break), E1 (pause sequence).
- Emits one key event per complete sequence, carrying {ext, rel, code}.
- Events are buffered in a small FIFO and drained by the display/control logic through a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.
- PAUSE_TAIL, 7, bytes to swallow after E1 (full Set-2 pause sequence is E1 14 77 E1 F0 14 F0 77).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  byte from the receiver
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle
- rx_err  in  1  one-cycle strobe; receiver frame/parity error
- ev_code  out  8  event scan code (FIFO head)
- ev_ext  out  1  event had the E0 prefix
- ev_rel  out  1  event is a key release (F0 prefix)
- ev_valid  out  1  FIFO not empty
- ev_ready  in  1  consumer accepts the head when ev_valid && ev_ready
- ovf  out  1  sticky: an event was dropped because the FIFO was full
- ovf_clr  in  1  clears ovf

Behaviour:
- Clock, reset, polarity: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: FSM = IDLE, FIFO empty, ev_valid=0, ev_code=0, ev_ext=0, ev_rel=0, ovf=0, skip counter=0.
- FSM states:
  - IDLE, EXT, BRK, EXT_BRK, PAUSE.
  - FSM advances only on cycles where rx_valid=1.
- Transitions from IDLE:
  - E0 -> EXT
  - F0 -> BRK
  - E1 -> PAUSE, with skip counter loaded to PAUSE_TAIL
  - any other byte -> push {0,0,byte}, stay in IDLE
- Transitions from EXT:
  - F0 -> EXT_BRK
  - E0 -> stay in EXT (redundant prefix ignored)
  - other byte -> push {1,0,byte}, go to IDLE
- Transitions from BRK:
  - F0 or E0 -> IDLE, nothing pushed (malformed sequence)
  - other byte -> push {0,1,byte}, go to IDLE
- Transitions from EXT_BRK:
  - F0 or E0 -> IDLE, nothing pushed
  - other byte -> push {1,1,byte}, go to IDLE
- PAUSE:
  - Each byte decrements the skip counter.
  - When the counter reaches 0: push {1,0,8'hE1}, go to IDLE. No break event is ever emitted for pause.
- Bytes AA (BAT OK) and FA (ACK) in IDLE are treated as ordinary codes and pushed.
- rx_err: forces the FSM to IDLE and clears the skip counter in the same cycle. Any concurrent rx_valid byte is discarded. FIFO contents are untouched.
- Latency: the final byte's rx_valid at cycle N makes the entry written at edge N+1. If the FIFO was empty, ev_valid goes high in cycle N+1.
- FIFO behaviour:
  - First-word fall-through: ev_* always reflect the head entry.
  - Head values are don't-care while ev_valid=0, but are driven 0 after reset.
- Push when full:
  - Without a same-cycle pop: the event is dropped and ovf is set.
  - With a same-cycle pop (ev_valid && ev_ready): the push is accepted and occupancy is unchanged.
- Pop when empty: ignored.
- Push and pop on an empty FIFO: the push is accepted and ev_valid rises next cycle (no bypass).
- ovf_clr and a new overflow in the same cycle: ovf stays 1 (set wins).
- Pointers: log2(FIFO_DEPTH) bits plus a wrap bit. full = address bits equal and wrap bits differ.

Optional Feature:
- Macro: PS2_REPEAT_FILTER_EN.
- When defined:
  - The block holds a last_make register {valid, ext, code}.
  - A make event equal to last_make is suppressed; the typematic auto-repeat never reaches the FIFO.
  - A break event whose {ext, code} matches last_make clears last_make.valid.
  - A new, different make event overwrites last_make.
  - Reset and rx_err clear last_make.valid.
- When undefined: every make event is pushed, including auto-repeats, and no last_make register exists.

Decomposition:
- Package ps2_pkg:
  - Constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1.
  - Default PAUSE_TAIL value.
  - FSM state enum.
  - Packed event typedef {ext, rel, code[7:0]} (10 bits).
- One sub-module, ps2_event_fifo: a parameterised synchronous FWFT FIFO with full/empty flags, instantiated once. The FSM and filter stay in the top.

Test Plan:
- Bytes 1C, F0 1C, ready=1 -> two events {0,0,1C} then {0,1,1C}; ev_valid high in the cycle after each final byte.
- E0 75, E0 F0 75 -> events {1,0,75} then {1,1,75}; prefixes alone produce no event.
- Full 8-byte pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event {1,0,E1}; then 1C -> {0,0,1C}.
- ready=0, 5 make codes with FIFO_DEPTH=4 -> 4 events held, ovf=1. Draining yields the first 4 codes in order. ovf_clr -> ovf=0. Full FIFO with simultaneous push and pop -> no overflow.
- F0 then rx_err, then 1C -> event {0,0,1C} (break prefix discarded). Reset asserted with 3 entries queued -> ev_valid=0 immediately, ovf=0.
- With PS2_REPEAT_FILTER_EN: 1C 1C 1C F0 1C 1C -> events make 1C, break 1C, make 1C. Without the macro: all five make/break events appear.
